// File: rtl/divider_nonrestoring_serial_if.sv
// Operand/result bus for the serial non-restoring divider.
// Both directions use valid/ready: a transfer happens on a rising clock edge where valid and
// ready are both high; the sender holds its payload stable while valid is high and ready is low.
interface divider_nonrestoring_serial_if #(
   parameter int WORD_WIDTH = 36
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WORD_WIDTH-1:0] dividend;
   logic [WORD_WIDTH-1:0] divisor;
   logic                  signed_op;
   logic                  out_valid;
   logic                  out_ready;
   logic [WORD_WIDTH-1:0] quotient;
   logic [WORD_WIDTH-1:0] remainder;
   logic                  divide_by_zero;

   modport master (
      output in_valid, dividend, divisor, signed_op, out_ready,
      input  in_ready, out_valid, quotient, remainder, divide_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, signed_op, out_ready,
      output in_ready, out_valid, quotient, remainder, divide_by_zero
   );
endinterface

// File: rtl/divider_nonrestoring_serial.sv
// Serial non-restoring signed/unsigned divider: one quotient bit per cycle, IDLE->CALC->FIXUP->DONE.
// Define DIVIDER_DIVZERO_BYPASS_EN to send a zero divisor straight from IDLE to DONE.
module divider_nonrestoring_serial #(
   parameter int WORD_WIDTH = 36
) (
   input  logic                             clock,
   input  logic                             reset_n,
   divider_nonrestoring_serial_if.slave     if_bus,
   output logic [1:0]                       o_dbg_state
);
   localparam int W  = WORD_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [W:0]      r_p;
   logic [W-1:0]    r_q;
   logic [W-1:0]    r_d;
   logic [W-1:0]    r_dividend;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_zero;
   logic [W-1:0]    r_quotient;
   logic [W-1:0]    r_remainder;
   logic            r_dbz;
   logic            r_in_ready;
   logic            r_out_valid;

   // Conditional two's-complement negate: (x ^ {W{n}}) + n
   function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic n);
      return (x ^ {W{n}}) + {{(W-1){1'b0}}, n};
   endfunction

   logic            w_accept;
   logic            w_div_zero;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [W-1:0]    w_mag_a;
   logic [W-1:0]    w_mag_b;

   assign w_accept   = if_bus.in_valid & r_in_ready;
   assign w_div_zero = (if_bus.divisor == '0);
   assign w_neg_a    = if_bus.signed_op & if_bus.dividend[W-1];
   assign w_neg_b    = if_bus.signed_op & if_bus.divisor[W-1];
   assign w_mag_a    = cond_neg(if_bus.dividend, w_neg_a);
   assign w_mag_b    = cond_neg(if_bus.divisor, w_neg_b);

   // Single W+1 bit add/sub shared by the CALC steps and the FIXUP remainder correction
   logic            w_sub;
   logic [W:0]      w_p_in;
   logic [W:0]      w_addend;
   logic [W:0]      w_sum;

   always_comb begin
      w_sub  = ~r_p[W];
      w_p_in = {r_p[W-1:0], r_q[W-1]};
      if (r_state == S_FIXUP) begin
         w_sub  = 1'b0;
         w_p_in = r_p;
      end
   end

   assign w_addend = {1'b0, r_d} ^ {(W+1){w_sub}};
   assign w_sum    = w_p_in + w_addend + {{W{1'b0}}, w_sub};

   logic [W:0]      w_p_fixed;
   logic [W-1:0]    w_q_res;
   logic [W-1:0]    w_r_res;

   // Most-negative / -1 needs no special case: magnitude quotient 2^(W-1) with neg_q=0 is already
   // the most-negative pattern, and the remainder magnitude is 0.
   assign w_p_fixed = r_p[W] ? w_sum : r_p;
   assign w_q_res   = r_zero ? {W{1'b1}} : cond_neg(r_q, r_neg_q);
   assign w_r_res   = r_zero ? r_dividend : cond_neg(w_p_fixed[W-1:0], r_neg_r);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_p         <= '0;
         r_q         <= '0;
         r_d         <= '0;
         r_dividend  <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_zero      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_p        <= '0;
                  r_q        <= w_mag_a;
                  r_d        <= w_mag_b;
                  r_dividend <= if_bus.dividend;
                  r_neg_q    <= w_neg_a ^ w_neg_b;
                  r_neg_r    <= w_neg_a;
                  r_zero     <= w_div_zero;
                  r_cnt      <= CW'(W - 1);
`ifdef DIVIDER_DIVZERO_BYPASS_EN
                  if (w_div_zero) begin
                     r_quotient  <= {W{1'b1}};
                     r_remainder <= if_bus.dividend;
                     r_dbz       <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                  end
`else
                  r_state <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               r_p <= w_sum;
               r_q <= {r_q[W-2:0], ~w_sum[W]};
               if (r_cnt == '0) begin
                  r_state <= S_FIXUP;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_FIXUP: begin
               r_p         <= w_p_fixed;
               r_quotient  <= w_q_res;
               r_remainder <= w_r_res;
               r_dbz       <= r_zero;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (if_bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_bus.in_ready       = r_in_ready;
   assign if_bus.out_valid      = r_out_valid;
   assign if_bus.quotient       = r_quotient;
   assign if_bus.remainder      = r_remainder;
   assign if_bus.divide_by_zero = r_dbz;
   assign o_dbg_state           = r_state;
endmodule

// File: tb/tb_divider_nonrestoring_serial.sv
// Directed bench for the serial divider at WORD_WIDTH=8; each scenario task checks inline.
module tb_divider_nonrestoring_serial;
   localparam int W = 8;
`ifdef DIVIDER_DIVZERO_BYPASS_EN
   localparam int DZ_LAT = 1;
`else
   localparam int DZ_LAT = 10;
`endif

   logic       clock;
   logic       reset_n;
   logic [1:0] dbg_state;
   int         checks;
   int         failures;

   divider_nonrestoring_serial_if #(.WORD_WIDTH(W)) bus ();

   divider_nonrestoring_serial #(.WORD_WIDTH(W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .if_bus      (bus),
      .o_dbg_state (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Called 1ns after a rising edge with the unit idle; returns edges from accept (inclusive) to out_valid.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
      bus.dividend  = a;
      bus.divisor   = b;
      bus.signed_op = s;
      bus.in_valid  = 1'b1;
      @(posedge clock); #1;
      bus.in_valid  = 1'b0;
      bus.dividend  = W'($urandom_range(0, 255));
      bus.divisor   = W'($urandom_range(0, 255));
      bus.signed_op = ~s;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.quotient !== 8'h00 || bus.remainder !== 8'h00) begin failures++; $display("FAIL reset_results got=%h/%h exp=00/00", bus.quotient, bus.remainder); end
      checks++; if (bus.divide_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", bus.divide_by_zero); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_unsigned();
      int lat;
      run_op(8'd200, 8'd7, 1'b0, lat);
      checks++; if (lat !== 10) begin failures++; $display("FAIL unsigned_latency got=%0d exp=10", lat); end
      checks++; if (bus.quotient !== 8'd28) begin failures++; $display("FAIL unsigned_q got=%0d exp=28", bus.quotient); end
      checks++; if (bus.remainder !== 8'd4) begin failures++; $display("FAIL unsigned_r got=%0d exp=4", bus.remainder); end
      checks++; if (bus.divide_by_zero !== 1'b0) begin failures++; $display("FAIL unsigned_dbz got=%b exp=0", bus.divide_by_zero); end
      consume();
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL unsigned_release got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid); end
      run_op(8'hFF, 8'h01, 1'b0, lat);
      checks++; if (bus.quotient !== 8'hFF || bus.remainder !== 8'h00) begin failures++; $display("FAIL unsigned_ff_by_1 got=%h/%h exp=ff/00", bus.quotient, bus.remainder); end
      consume();
      run_op(8'h80, 8'hFF, 1'b0, lat);
      checks++; if (bus.quotient !== 8'h00 || bus.remainder !== 8'h80) begin failures++; $display("FAIL unsigned_msb got=%h/%h exp=00/80", bus.quotient, bus.remainder); end
      consume();
   endtask

   task automatic test_signed();
      int lat;
      run_op(8'hF9, 8'h02, 1'b1, lat);
      checks++; if (bus.quotient !== 8'hFD || bus.remainder !== 8'hFF) begin failures++; $display("FAIL signed_neg7_by_2 got=%h/%h exp=fd/ff", bus.quotient, bus.remainder); end
      consume();
      run_op(8'h07, 8'hFE, 1'b1, lat);
      checks++; if (bus.quotient !== 8'hFD || bus.remainder !== 8'h01) begin failures++; $display("FAIL signed_7_by_neg2 got=%h/%h exp=fd/01", bus.quotient, bus.remainder); end
      consume();
      run_op(8'hEC, 8'hFB, 1'b1, lat);
      checks++; if (bus.quotient !== 8'h04 || bus.remainder !== 8'h00) begin failures++; $display("FAIL signed_neg20_by_neg5 got=%h/%h exp=04/00", bus.quotient, bus.remainder); end
      consume();
   endtask

   task automatic test_div_zero();
      int lat;
      run_op(8'h55, 8'h00, 1'b0, lat);
      checks++; if (lat !== DZ_LAT) begin failures++; $display("FAIL divzero_latency got=%0d exp=%0d", lat, DZ_LAT); end
      checks++; if (bus.quotient !== 8'hFF || bus.remainder !== 8'h55) begin failures++; $display("FAIL divzero_results got=%h/%h exp=ff/55", bus.quotient, bus.remainder); end
      checks++; if (bus.divide_by_zero !== 1'b1) begin failures++; $display("FAIL divzero_flag got=%b exp=1", bus.divide_by_zero); end
      consume();
      run_op(8'h9C, 8'h00, 1'b1, lat);
      checks++; if (bus.quotient !== 8'hFF || bus.remainder !== 8'h9C || bus.divide_by_zero !== 1'b1) begin failures++; $display("FAIL divzero_signed got=%h/%h/%b exp=ff/9c/1", bus.quotient, bus.remainder, bus.divide_by_zero); end
      consume();
   endtask

   task automatic test_overflow();
      int lat;
      run_op(8'h80, 8'hFF, 1'b1, lat);
      checks++; if (bus.quotient !== 8'h80 || bus.remainder !== 8'h00) begin failures++; $display("FAIL overflow_results got=%h/%h exp=80/00", bus.quotient, bus.remainder); end
      checks++; if (bus.divide_by_zero !== 1'b0) begin failures++; $display("FAIL overflow_dbz got=%b exp=0", bus.divide_by_zero); end
      consume();
   endtask

   task automatic test_hold();
      int lat;
      run_op(8'd100, 8'd7, 1'b0, lat);
      bus.in_valid = 1'b1;
      bus.dividend = 8'd9;
      bus.divisor  = 8'd3;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || dbg_state !== 2'd3) begin
            failures++;
            $display("FAIL hold_cycle%0d got v=%b rdy=%b q=%0d r=%0d st=%0d exp 1/0/14/2/3", i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, dbg_state);
         end
      end
      bus.in_valid = 1'b0;
      consume();
      checks++; if (dbg_state !== 2'd0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got st=%0d rdy=%b exp 0/1", dbg_state, bus.in_ready); end
      run_op(8'd9, 8'd3, 1'b0, lat);
      checks++; if (bus.quotient !== 8'd3 || bus.remainder !== 8'd0 || lat !== 10) begin failures++; $display("FAIL hold_next_op got=%0d/%0d lat=%0d exp=3/0 lat=10", bus.quotient, bus.remainder, lat); end
      consume();
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(8'd79, 8'd7, 1'b0, lat);
      checks++; if (bus.quotient !== 8'd11 || bus.remainder !== 8'd2) begin failures++; $display("FAIL b2b_first got=%0d/%0d exp=11/2", bus.quotient, bus.remainder); end
      bus.in_valid  = 1'b1;
      bus.dividend  = 8'd250;
      bus.divisor   = 8'd16;
      bus.signed_op = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      checks++; if (dbg_state !== 2'd0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_no_accept got st=%0d rdy=%b exp 0/1", dbg_state, bus.in_ready); end
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL b2b_accept got st=%0d exp=1", dbg_state); end
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      checks++; if (bus.quotient !== 8'd15 || bus.remainder !== 8'd10 || lat !== 10) begin failures++; $display("FAIL b2b_second got=%0d/%0d lat=%0d exp=15/10 lat=10", bus.quotient, bus.remainder, lat); end
      consume();
   endtask

   task automatic test_reset_mid();
      int lat;
      bus.dividend  = 8'd123;
      bus.divisor   = 8'd5;
      bus.signed_op = 1'b0;
      bus.in_valid  = 1'b1;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL midreset_in_calc got st=%0d exp=1", dbg_state); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 8'h00 || bus.remainder !== 8'h00 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL midreset_values got v=%b rdy=%b q=%h r=%h st=%0d exp 0/1/00/00/0", bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, dbg_state);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      run_op(8'd100, 8'd10, 1'b0, lat);
      checks++; if (bus.quotient !== 8'd10 || bus.remainder !== 8'd0 || lat !== 10) begin failures++; $display("FAIL midreset_fresh_op got=%0d/%0d lat=%0d exp=10/0 lat=10", bus.quotient, bus.remainder, lat); end
      consume();
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset_n       = 1'b1;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.signed_op = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/divider_nonrestoring_serial.md
Name: divider_nonrestoring_serial

Overview:
- Iterative signed/unsigned integer divider: one conditional add or subtract of the divisor per cycle, one quotient bit per cycle.
- Inverse of the ±A±B adder: the datapath reuses the same negate-by-XOR-plus-one idiom around a single WORD_WIDTH+1 add/sub.
- Sits beside the ALU as a multi-cycle functional unit behind a valid/ready handshake.

Parameters:
WORD_WIDTH, 36, operand/result width in bits (≥2)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands and op presented
in_ready  out  1  unit can accept; high only in IDLE
dividend  in  WORD_WIDTH  numerator
divisor  in  WORD_WIDTH  denominator
signed_op  in  1  1 = two's-complement operands, 0 = unsigned
out_valid  out  1  results valid; high only in DONE
out_ready  in  1  consumer takes results
quotient  out  WORD_WIDTH  registered result
remainder  out  WORD_WIDTH  registered result; sign follows dividend
divide_by_zero  out  1  registered flag, valid with out_valid

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, divide_by_zero=0, all internal registers 0.
- States: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE
  - Accept on clock edge with in_valid&in_ready.
  - Latch magnitudes: |x| = (x ^ {W{neg}}) + neg, where neg = signed_op & msb.
  - Latch neg_q = neg_dividend ^ neg_divisor, neg_r = neg_dividend, zero flag = (divisor==0).
  - Step counter = WORD_WIDTH-1.
- CALC: exactly WORD_WIDTH cycles.
  - Partial remainder P is WORD_WIDTH+1 bits, signed.
  - Each cycle: shift {P,Q} left 1. If P ≥ 0: P -= D, else P += D. New Q lsb = ~P_new[msb].
  - Counter decrements; leave CALC when counter==0.
- FIXUP: 1 cycle.
  - If P<0: P += D.
  - Apply signs: Q negated if neg_q, R negated if neg_r.
  - Divide-by-zero override: quotient = all ones, remainder = original dividend, divide_by_zero=1.
  - Signed overflow (dividend = most negative, divisor = -1): quotient = most negative, remainder = 0.
- DONE: out_valid=1. Outputs held stable until out_valid&out_ready, then -> IDLE, in_ready=1 on the next cycle.
- Latency: out_valid asserts WORD_WIDTH+2 edges after the accepting edge. Throughput: one op per WORD_WIDTH+3 cycles minimum.
- in_valid is ignored outside IDLE. Operand inputs are sampled only at accept; later changes have no effect.
- out_ready is ignored outside DONE. No back-to-back accept in the cycle results are consumed.
- reset_n asserted mid-operation (any state): immediate return to reset values; the in-flight op is discarded.
- Unsigned mode: msb is magnitude, never negated. Unsigned 0xFF..F / 1 is legal.
- Truncating division: quotient rounds toward zero.

Optional Feature:
- Macro: DIVIDER_DIVZERO_BYPASS_EN.
- Defined: divisor==0 at accept goes IDLE -> DONE directly; override results visible 1 edge after accept.
- Undefined: zero divisor takes the full CALC/FIXUP path. Same override results, standard WORD_WIDTH+2 latency.
- All other behaviour is identical either way.

Test Plan (WORD_WIDTH=8):
- Unsigned 200/7, signed_op=0 -> quotient=28, remainder=4, divide_by_zero=0; out_valid exactly 10 edges after accept.
- Signed -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF); signed 7/-2 -> quotient=-3, remainder=1.
- Divisor 0, dividend 0x55 -> quotient=0xFF, remainder=0x55, divide_by_zero=1.
  - Latency 10 edges without the macro, 1 edge with it.
- Signed 0x80/0xFF -> quotient=0x80, remainder=0x00, divide_by_zero=0.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored.
  - Release -> IDLE, next op accepted.
- Assert reset_n=0 mid-CALC (cycle 4) -> out_valid=0, in_ready=1, quotient=remainder=0 immediately.
  - A fresh 100/10 after release -> 10, 0.
